// File: rtl/reg_file.sv
// 32-entry integer register file for the single-cycle RISC-V core.
// Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
// x0 is hardwired to zero and has no storage. An optional bypass lets a
// reader see the data being written in the same cycle.
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  WE3,
   input  logic [ADDR_WIDTH-1:0] A1,
   input  logic [ADDR_WIDTH-1:0] A2,
   input  logic [ADDR_WIDTH-1:0] A3,
   input  logic [DATA_WIDTH-1:0] WD3,
   output logic [DATA_WIDTH-1:0] RD1,
   output logic [DATA_WIDTH-1:0] RD2
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Entries 1..DEPTH-1 only; index 0 has no storage and is never read.
   logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
   logic [DATA_WIDTH-1:0] regs_d [1:DEPTH-1];

   logic wr_en;
   logic hit1;
   logic hit2;

   // A write is only real when enabled and not targeting x0.
   assign wr_en = WE3 && (A3 != '0);

   // Next-state of storage: hold everything, update the addressed entry.
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[A3] = WD3;
      end
   end

   // Storage flops; reset clears asynchronously and blocks writes while high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Bypass hits: a pending write to the same non-zero register as the reader.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      if (BYPASS && !rst && wr_en) begin
         hit1 = (A3 == A1);
         hit2 = (A3 == A2);
      end
   end

   // Read port 1: zero on x0 or during reset, else bypass data or storage.
   always_comb begin
      RD1 = '0;
      if (rst || (A1 == '0)) begin
         RD1 = '0;
      end else if (hit1) begin
         RD1 = WD3;
      end else begin
         RD1 = regs_q[A1];
      end
   end

   // Read port 2: same rules as port 1, fully independent.
   always_comb begin
      RD2 = '0;
      if (rst || (A2 == '0)) begin
         RD2 = '0;
      end else if (hit2) begin
         RD2 = WD3;
      end else begin
         RD2 = regs_q[A2];
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one instance with bypass, one without, sharing
// all stimulus. Each scenario task checks its own expected values.
module tb_reg_file;

   logic        clk;
   logic        rst;
   logic        we3;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic [4:0]  a3;
   logic [31:0] wd3;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] nb_rd1;
   logic [31:0] nb_rd2;

   int checks;
   int failures;

   reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .WE3(we3), .A1(a1), .A2(a2), .A3(a3),
      .WD3(wd3), .RD1(rd1), .RD2(rd2)
   );

   reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .WE3(we3), .A1(a1), .A2(a2), .A3(a3),
      .WD3(wd3), .RD1(nb_rd1), .RD2(nb_rd2)
   );

   // Clock: 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single write across one rising edge; enable dropped just after it.
   task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      we3 = 1'b1;
      a3  = addr;
      wd3 = data;
      @(posedge clk);
      #1;
      we3 = 1'b0;
   endtask

   task automatic test_reset();
      // Outputs forced to zero under reset even with a matching bypass write
      rst = 1'b1; we3 = 1'b1; a3 = 5'd5; wd3 = 32'hCAFE_F00D; a1 = 5'd5; a2 = 5'd5;
      #1;
      checks++;
      if (rd1 !== 32'h0) begin failures++; $display("FAIL reset_rd1 got=%h exp=%h", rd1, 32'h0); end
      checks++;
      if (rd2 !== 32'h0) begin failures++; $display("FAIL reset_rd2 got=%h exp=%h", rd2, 32'h0); end
      @(negedge clk);
      we3 = 1'b0;
      rst = 1'b0;
      // x5 gets a value, then async reset mid-cycle clears it without an edge
      do_write(5'd5, 32'hDEAD_BEEF);
      a1 = 5'd5;
      #1;
      checks++;
      if (rd1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL reset_prewrite got=%h exp=%h", rd1, 32'hDEAD_BEEF); end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (rd1 !== 32'h0) begin failures++; $display("FAIL reset_async got=%h exp=%h", rd1, 32'h0); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (rd1 !== 32'h0) begin failures++; $display("FAIL reset_release got=%h exp=%h", rd1, 32'h0); end
      @(posedge clk);
      #1;
      checks++;
      if (nb_rd1 !== 32'h0) begin failures++; $display("FAIL reset_after_edge got=%h exp=%h", nb_rd1, 32'h0); end
   endtask

   task automatic test_basic();
      do_write(5'd7, 32'h1234_5678);
      a1 = 5'd7; a2 = 5'd7;
      #1;
      checks++;
      if (rd1 !== 32'h1234_5678) begin failures++; $display("FAIL basic_rd1 got=%h exp=%h", rd1, 32'h1234_5678); end
      checks++;
      if (rd2 !== 32'h1234_5678) begin failures++; $display("FAIL basic_rd2 got=%h exp=%h", rd2, 32'h1234_5678); end
      a1 = 5'd6; a2 = 5'd8;
      #1;
      checks++;
      if (rd1 !== 32'h0) begin failures++; $display("FAIL basic_x6 got=%h exp=%h", rd1, 32'h0); end
      checks++;
      if (rd2 !== 32'h0) begin failures++; $display("FAIL basic_x8 got=%h exp=%h", rd2, 32'h0); end
   endtask

   task automatic test_x0();
      do_write(5'd0, 32'hFFFF_FFFF);
      a1 = 5'd0; a2 = 5'd0;
      #1;
      checks++;
      if (rd1 !== 32'h0) begin failures++; $display("FAIL x0_stored got=%h exp=%h", rd1, 32'h0); end
      // Pending write to x0 must not bypass
      @(negedge clk);
      we3 = 1'b1; a3 = 5'd0; wd3 = 32'hAAAA_AAAA;
      #1;
      checks++;
      if (rd1 !== 32'h0) begin failures++; $display("FAIL x0_bypass_rd1 got=%h exp=%h", rd1, 32'h0); end
      checks++;
      if (rd2 !== 32'h0) begin failures++; $display("FAIL x0_bypass_rd2 got=%h exp=%h", rd2, 32'h0); end
      @(posedge clk);
      #1;
      we3 = 1'b0;
   endtask

   task automatic test_bypass();
      do_write(5'd3, 32'h0000_0010);
      do_write(5'd4, 32'h0000_0005);
      @(negedge clk);
      we3 = 1'b1; a3 = 5'd3; wd3 = 32'h0000_0020; a1 = 5'd3; a2 = 5'd4;
      #1;
      checks++;
      if (rd1 !== 32'h0000_0020) begin failures++; $display("FAIL bypass_rd1 got=%h exp=%h", rd1, 32'h20); end
      checks++;
      if (rd2 !== 32'h0000_0005) begin failures++; $display("FAIL bypass_rd2 got=%h exp=%h", rd2, 32'h5); end
      checks++;
      if (nb_rd1 !== 32'h0000_0010) begin failures++; $display("FAIL nobypass_rd1 got=%h exp=%h", nb_rd1, 32'h10); end
      // Same address on both ports sees the bypass on both
      a2 = 5'd3;
      #1;
      checks++;
      if (rd2 !== 32'h0000_0020) begin failures++; $display("FAIL bypass_same_rd2 got=%h exp=%h", rd2, 32'h20); end
      checks++;
      if (nb_rd2 !== 32'h0000_0010) begin failures++; $display("FAIL nobypass_same_rd2 got=%h exp=%h", nb_rd2, 32'h10); end
      @(posedge clk);
      #1;
      we3 = 1'b0;
      #1;
      checks++;
      if (nb_rd1 !== 32'h0000_0020) begin failures++; $display("FAIL nobypass_after got=%h exp=%h", nb_rd1, 32'h20); end
      checks++;
      if (rd1 !== 32'h0000_0020) begin failures++; $display("FAIL bypass_after got=%h exp=%h", rd1, 32'h20); end
   endtask

   task automatic test_collision();
      @(negedge clk);
      rst = 1'b1; we3 = 1'b1; a3 = 5'd9; wd3 = 32'h55; a1 = 5'd9; a2 = 5'd9;
      @(posedge clk);
      @(negedge clk);
      we3 = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (nb_rd1 !== 32'h0) begin failures++; $display("FAIL collision_x9 got=%h exp=%h", nb_rd1, 32'h0); end
      // First edge after release captures the write
      do_write(5'd9, 32'h55);
      #1;
      checks++;
      if (nb_rd1 !== 32'h55) begin failures++; $display("FAIL collision_rewrite got=%h exp=%h", nb_rd1, 32'h55); end
      checks++;
      if (rd2 !== 32'h55) begin failures++; $display("FAIL collision_rewrite_rd2 got=%h exp=%h", rd2, 32'h55); end
   endtask

   task automatic test_sweep();
      logic [31:0] e1;
      logic [31:0] e2;
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), 32'(i) * 32'h0101_0101);
      end
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i);
         a2 = 5'(31 - i);
         e1 = 32'(i) * 32'h0101_0101;
         e2 = 32'(31 - i) * 32'h0101_0101;
         #1;
         checks++;
         if (rd1 !== e1) begin failures++; $display("FAIL sweep_rd1 a=%0d got=%h exp=%h", i, rd1, e1); end
         checks++;
         if (rd2 !== e2) begin failures++; $display("FAIL sweep_rd2 a=%0d got=%h exp=%h", 31 - i, rd2, e2); end
         checks++;
         if (nb_rd1 !== e1) begin failures++; $display("FAIL sweep_nb_rd1 a=%0d got=%h exp=%h", i, nb_rd1, e1); end
      end
   endtask

   // Scenario sequence and final report
   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
      test_reset();
      test_basic();
      test_x0();
      test_bypass();
      test_collision();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
